// File: rtl/mitll_merge_pkg.sv
// Shared constants and helpers for the toggle-encoded pulse merger.
package mitll_merge_pkg;

  localparam int MODE_BUF   = 0;
  localparam int MODE_LOSSY = 1;

  // Pointer width for an N-way round robin; never narrower than one bit.
  function automatic int ptr_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mitll_rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping to 0.
module mitll_rr_arb
  import mitll_merge_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic found;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    // Wrapped half of the search only runs when nothing at or above ptr requested.
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j < int'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mitll_merge_nbuf.sv
// N-input toggle-encoded pulse merger with per-channel pending counters and
// round-robin drain, or a raw-cell emulation where coincident pulses collapse.
module mitll_merge_nbuf
  import mitll_merge_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = 3,
  parameter int LOSSY = MODE_BUF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  output logic         out,
  output logic [N-1:0] overflow,
  output logic         coll,
  output logic         busy
);

  localparam int               PW       = ptr_w(N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit               IS_LOSSY = (LOSSY == MODE_LOSSY);

  logic [N-1:0]            in_q, in_d;
  logic [N-1:0][CNT_W-1:0] pend_q, pend_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    out_q, out_d;
  logic [N-1:0]            ovf_q, ovf_d;
  logic                    coll_q, coll_d;
  logic                    busy_q, busy_d;
  logic                    hit_q, hit_d;

  logic [N-1:0]  det;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [PW-1:0] gidx;

  // Arbitration sees only registered counters, so a fresh pulse waits one edge.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = !IS_LOSSY && (pend_q[i] != '0);
    end
  end

  mitll_rr_arb #(
    .N  (N),
    .PW (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  always_comb begin
    det    = in ^ in_q;
    in_d   = in;
    pend_d = pend_q;
    ptr_d  = ptr_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    hit_d  = 1'b0;
    gidx   = '0;
    busy_d = 1'b0;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    coll_d = |(det & (det - N'(1)));

    for (int j = 0; j < N; j++) begin
      if (gnt[j]) gidx = PW'(j);
    end

    if (IS_LOSSY) begin
      hit_d = |det;
      out_d = out_q ^ hit_q;
    end else begin
      if (gnt_valid) begin
        out_d = ~out_q;
        ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
      end
      for (int i = 0; i < N; i++) begin
        if (det[i] && !gnt[i] && (pend_q[i] == CNT_MAX)) begin
          ovf_d[i] = 1'b1;
        end else if (det[i] && !gnt[i]) begin
          pend_d[i] = pend_q[i] + CNT_W'(1);
        end else if (!det[i] && gnt[i]) begin
          pend_d[i] = pend_q[i] - CNT_W'(1);
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      busy_d = busy_d | (pend_d[i] != '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      // NOTE: the counter array is reset explicitly; a reset must drop every pending pulse.
      pend_q <= '0;
      ptr_q  <= '0;
      out_q  <= 1'b0;
      ovf_q  <= '0;
      coll_q <= 1'b0;
      busy_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      in_q   <= in_d;
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      coll_q <= coll_d;
      busy_q <= busy_d;
      hit_q  <= hit_d;
    end
  end

  assign out      = out_q;
  assign overflow = ovf_q;
  assign coll     = coll_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mitll_merge_nbuf.sv
// Directed bench for mitll_merge_nbuf: three configurations checked every cycle
// against a queue/counter model, plus hand-computed literal expectations.
module tb_mitll_merge_nbuf;

  logic       clk;
  logic       rst_n;
  logic [1:0] in_a, in_b;
  logic [3:0] in_c;
  logic       out_a, out_b, out_c;
  logic [1:0] ovf_a, ovf_b;
  logic [3:0] ovf_c;
  logic       coll_a, coll_b, coll_c;
  logic       busy_a, busy_b, busy_c;

  mitll_merge_nbuf #(.N(2), .CNT_W(3), .LOSSY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a),
    .overflow(ovf_a), .coll(coll_a), .busy(busy_a));

  mitll_merge_nbuf #(.N(2), .CNT_W(3), .LOSSY(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b),
    .overflow(ovf_b), .coll(coll_b), .busy(busy_b));

  mitll_merge_nbuf #(.N(4), .CNT_W(2), .LOSSY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .out(out_c),
    .overflow(ovf_c), .coll(coll_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model configuration and state, one slot per instance.
  int mn[3]      = '{2, 2, 4};
  int mmax[3]    = '{7, 7, 3};
  bit mlossy[3]  = '{1'b0, 1'b1, 1'b0};
  int m_pend[3][16];
  int m_ptr[3];
  int m_out[3];
  int m_ovf[3];
  int m_coll[3];
  int m_busy[3];
  int m_lp[3];
  int m_prev[3];
  int q_gr[3][$];
  int tog[3];
  int last_out[3];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) m_pend[d][i] = 0;
      m_ptr[d]  = 0;
      m_out[d]  = 0;
      m_ovf[d]  = 0;
      m_coll[d] = 0;
      m_busy[d] = 0;
      m_lp[d]   = 0;
      m_prev[d] = 0;
    end
  endtask

  function automatic int in_of(input int d);
    case (d)
      0:       return int'(in_a);
      1:       return int'(in_b);
      default: return int'(in_c);
    endcase
  endfunction

  task automatic get_dut(input int d, output int o, output int ov, output int co, output int bu);
    case (d)
      0:       begin o = int'(out_a); ov = int'(ovf_a); co = int'(coll_a); bu = int'(busy_a); end
      1:       begin o = int'(out_b); ov = int'(ovf_b); co = int'(coll_b); bu = int'(busy_b); end
      default: begin o = int'(out_c); ov = int'(ovf_c); co = int'(coll_c); bu = int'(busy_c); end
    endcase
  endtask

  // One clock edge of the specified behaviour for instance d.
  task automatic model_step(input int d, input int inval);
    int det;
    int g;
    det = inval ^ m_prev[d];
    m_prev[d] = inval;
    m_coll[d] = ($countones(det) >= 2) ? 1 : 0;
    if (mlossy[d]) begin
      if (m_lp[d] != 0) m_out[d] = 1 - m_out[d];
      m_lp[d]   = (det != 0) ? 1 : 0;
      m_busy[d] = 0;
    end else begin
      g = -1;
      for (int k = 0; k < mn[d]; k++) begin
        int idx;
        idx = (m_ptr[d] + k) % mn[d];
        if (g < 0 && m_pend[d][idx] > 0) g = idx;
      end
      if (g >= 0) begin
        m_pend[d][g]--;
        m_out[d] = 1 - m_out[d];
        m_ptr[d] = (g + 1) % mn[d];
        q_gr[d].push_back(g);
      end
      for (int i = 0; i < mn[d]; i++) begin
        if (((det >> i) & 1) != 0) begin
          if (m_pend[d][i] < mmax[d]) m_pend[d][i]++;
          else m_ovf[d] = m_ovf[d] | (1 << i);
        end
      end
      m_busy[d] = 0;
      for (int i = 0; i < mn[d]; i++) if (m_pend[d][i] > 0) m_busy[d] = 1;
    end
  endtask

  // Advance one edge, step the model, then compare every output of every instance.
  task automatic tick();
    int o, ov, co, bu;
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) model_step(d, in_of(d));
    end
    for (int d = 0; d < 3; d++) begin
      get_dut(d, o, ov, co, bu);
      check($sformatf("d%0d_out", d), o, m_out[d]);
      check($sformatf("d%0d_overflow", d), ov, m_ovf[d]);
      check($sformatf("d%0d_coll", d), co, m_coll[d]);
      check($sformatf("d%0d_busy", d), bu, m_busy[d]);
      if (o != last_out[d]) tog[d]++;
      last_out[d] = o;
    end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 3; d++) begin
      tog[d] = 0;
      q_gr[d].delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    model_reset();
    for (int d = 0; d < 3; d++) last_out[d] = 0;
    clear_stats();
    tick();
    tick();
    check("rst_out_a", int'(out_a), 0);
    check("rst_busy_c", int'(busy_c), 0);
    check("rst_ovf_c", int'(ovf_c), 0);
    rst_n = 1'b1;

    // Staggered pulses on a 2-channel merge: one toggle per pulse, one edge later.
    clear_stats();
    in_a = 2'b01; in_b = 2'b01;
    tick();
    check("lat_a_edge1", int'(out_a), 0);
    in_a = 2'b11; in_b = 2'b11;
    tick();
    check("lat_a_edge2", int'(out_a), 1);
    tick();
    tick();
    tick();
    check("stagger_tog_a", tog[0], 2);
    check("stagger_tog_b", tog[1], 2);
    check("stagger_ord_len", q_gr[0].size(), 2);

    // Coincident pulses: buffered mode drains both, lossy mode collapses to one.
    clear_stats();
    in_a = 2'b00; in_b = 2'b00;
    tick();
    check("coinc_coll_a", int'(coll_a), 1);
    check("coinc_coll_b", int'(coll_b), 1);
    check("coinc_busy_b", int'(busy_b), 0);
    check("coinc_busy_a", int'(busy_a), 1);
    tick();
    check("coinc_coll_a_clr", int'(coll_a), 0);
    check("coinc_ptr_after_first", m_ptr[0], 1);
    tick();
    tick();
    tick();
    check("coinc_tog_a", tog[0], 2);
    check("coinc_tog_b", tog[1], 1);
    check("coinc_first_ch0", q_gr[0][0], 0);
    check("coinc_second_ch1", q_gr[0][1], 1);

    // Build pend=3 on channels 1 and 3 with ptr=2 on the 4-channel merge.
    clear_stats();
    in_c = 4'b0010;
    tick();
    tick();
    for (int e = 0; e < 5; e++) begin
      in_c = in_c ^ 4'b1010;
      tick();
    end
    check("rr_pend1", m_pend[2][1], 3);
    check("rr_pend3", m_pend[2][3], 3);
    check("rr_ptr", m_ptr[2], 2);
    for (int e = 0; e < 8; e++) tick();
    check("rr_total_grants", q_gr[2].size(), 11);
    check("rr_tog_c", tog[2], 11);
    check("rr_ovf_c", int'(ovf_c), 0);
    if (q_gr[2].size() == 11) begin
      check("rr_g0", q_gr[2][5], 3);
      check("rr_g1", q_gr[2][6], 1);
      check("rr_g2", q_gr[2][7], 3);
      check("rr_g3", q_gr[2][8], 1);
      check("rr_g4", q_gr[2][9], 3);
      check("rr_g5", q_gr[2][10], 1);
    end

    // Fresh start, then every channel toggling each edge to force saturation.
    rst_n = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    model_reset();
    tick();
    rst_n = 1'b1;
    clear_stats();
    for (int e = 0; e < 6; e++) begin
      in_c = ~in_c;
      tick();
    end
    check("sat_ovf_c", int'(ovf_c), 15);
    check("sat_busy_c", int'(busy_c), 1);
    for (int e = 0; e < 14; e++) tick();
    check("sat_tog_c", tog[2], 17);
    check("sat_ovf_sticky", int'(ovf_c), 15);
    check("sat_busy_drained", int'(busy_c), 0);

    // Reset while busy: immediate clear, nothing replayed after release.
    in_a = 2'b11; in_b = 2'b11;
    tick();
    check("mid_busy_a", int'(busy_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_out_a", int'(out_a), 0);
    check("mid_busy_a_clr", int'(busy_a), 0);
    check("mid_out_c", int'(out_c), 0);
    check("mid_ovf_c", int'(ovf_c), 0);
    check("mid_coll_b", int'(coll_b), 0);
    in_a = '0; in_b = '0; in_c = 4'b0101;
    tick();
    rst_n = 1'b1;
    clear_stats();
    tick();
    check("rel_coll_c", int'(coll_c), 1);
    tick();
    tick();
    tick();
    check("rel_tog_a", tog[0], 0);
    check("rel_tog_b", tog[1], 0);
    check("rel_tog_c", tog[2], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
